// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALUOp/funct into the ALU control code and selects operand B.
// Every output comes straight from a register, held in a 2-entry skid buffer.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic              alu_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [3:0]        ALU_control,
    output logic              illegal,
    output logic [CNT_W-1:0]  issue_cnt
);

    logic              r_outValid;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [3:0]        r_ctrl;
    logic              r_illegal;
    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidSrc1;
    logic [DATA_W-1:0] r_skidSrc2;
    logic [3:0]        r_skidCtrl;
    logic              r_skidIllegal;
    logic [CNT_W-1:0]  r_issueCnt;

    logic              w_inXfer;
    logic              w_outXfer;
    logic              w_outFree;
    logic [3:0]        w_ctrl;
    logic              w_illegal;
    logic [DATA_W-1:0] w_src2;

    assign in_ready  = ~r_skidValid;
    assign w_inXfer  = in_valid & ~r_skidValid;
    assign w_outXfer = r_outValid & out_ready;
    assign w_outFree = ~r_outValid | out_ready;
    assign w_src2    = alu_src ? {{(DATA_W-16){imm[15]}}, imm} : rt_data;

    // Undecodable encodings still flow through, flagged with 1111 and illegal.
    always_comb begin
        w_ctrl    = 4'b1111;
        w_illegal = 1'b1;
        case (alu_op)
            2'b00: begin w_ctrl = 4'b0010; w_illegal = 1'b0; end
            2'b01: begin w_ctrl = 4'b0110; w_illegal = 1'b0; end
            2'b10: begin
                case (funct)
                    6'b100000: begin w_ctrl = 4'b0010; w_illegal = 1'b0; end
                    6'b100010: begin w_ctrl = 4'b0110; w_illegal = 1'b0; end
                    6'b100100: begin w_ctrl = 4'b0000; w_illegal = 1'b0; end
                    6'b100101: begin w_ctrl = 4'b0001; w_illegal = 1'b0; end
                    6'b100111: begin w_ctrl = 4'b1100; w_illegal = 1'b0; end
                    6'b101010: begin w_ctrl = 4'b0111; w_illegal = 1'b0; end
                    default:   begin w_ctrl = 4'b1111; w_illegal = 1'b1; end
                endcase
            end
            default: begin w_ctrl = 4'b1111; w_illegal = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid    <= 1'b0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_ctrl        <= 4'b0000;
            r_illegal     <= 1'b0;
            r_skidValid   <= 1'b0;
            r_skidSrc1    <= '0;
            r_skidSrc2    <= '0;
            r_skidCtrl    <= 4'b0000;
            r_skidIllegal <= 1'b0;
        end else if (flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_outFree) begin
            // Skid only fills while the output is stalled, so it always drains first.
            if (r_skidValid) begin
                r_outValid  <= 1'b1;
                r_src1      <= r_skidSrc1;
                r_src2      <= r_skidSrc2;
                r_ctrl      <= r_skidCtrl;
                r_illegal   <= r_skidIllegal;
                r_skidValid <= 1'b0;
            end else if (w_inXfer) begin
                r_outValid <= 1'b1;
                r_src1     <= rs_data;
                r_src2     <= w_src2;
                r_ctrl     <= w_ctrl;
                r_illegal  <= w_illegal;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_inXfer) begin
            r_skidValid   <= 1'b1;
            r_skidSrc1    <= rs_data;
            r_skidSrc2    <= w_src2;
            r_skidCtrl    <= w_ctrl;
            r_skidIllegal <= w_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issueCnt <= '0;
        end else if (w_outXfer) begin
            r_issueCnt <= r_issueCnt + 1'b1;
        end
    end

    assign out_valid   = r_outValid;
    assign src1        = r_src1;
    assign src2        = r_src2;
    assign ALU_control = r_ctrl;
    assign illegal     = r_illegal;
    assign issue_cnt   = r_issueCnt;

endmodule
